// File: rtl/parallel_row_remainder_divider.sv
// Multi-cycle signed divider: ROWS lanes share one divisor and run restoring radix-2 steps in
// lockstep. Results truncate toward zero; remainders keep the dividend's sign (never normalised).
module parallel_row_remainder_divider #(
  parameter int ROWS       = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [ROWS*DATA_WIDTH-1:0] dividend_bus,
  input  logic [DATA_WIDTH-1:0]      divisor,
  output logic                       busy,
  output logic                       done,
  output logic                       div_by_zero,
  output logic [ROWS*DATA_WIDTH-1:0] quotient_bus,
  output logic [ROWS*DATA_WIDTH-1:0] remainder_bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ITERATE = 2'd1,
    S_FIX     = 2'd2
  } state_t;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    logic [W-1:0] res;
    if (neg) begin
      res = {W{1'b0}} - v;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Returns {next partial remainder, next shift register}; the quotient bit enters at the LSB
  // while dividend bits leave from the MSB, so one register serves both roles.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                               input logic [W-1:0] acc,
                                               input logic [W-1:0] dmag);
    logic [W:0]     trial;
    logic [W:0]     diff;
    logic [2*W-1:0] res;
    trial = {rem, acc[W-1]};
    diff  = trial - {1'b0, dmag};
    if (diff[W] == 1'b0) begin
      res = {diff[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      res = {trial[W-1:0], acc[W-2:0], 1'b0};
    end
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic              zero_q, zero_d;
  logic              dsor_neg_q, dsor_neg_d;
  logic [W-1:0]      dsor_mag_q, dsor_mag_d;
  logic [ROWS-1:0]   dvd_neg_q, dvd_neg_d;
  logic [W-1:0]      acc_q [ROWS];
  logic [W-1:0]      acc_d [ROWS];
  logic [W-1:0]      rem_q [ROWS];
  logic [W-1:0]      rem_d [ROWS];
  logic [ROWS*W-1:0] quo_q, quo_d;
  logic [ROWS*W-1:0] remo_q, remo_d;
  logic [2*W-1:0]    step_s;
  logic [W-1:0]      lane_s;

  // Next-state and datapath logic for capture, iteration and sign fix-up.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    dbz_d      = dbz_q;
    zero_d     = zero_q;
    dsor_neg_d = dsor_neg_q;
    dsor_mag_d = dsor_mag_q;
    dvd_neg_d  = dvd_neg_q;
    quo_d      = quo_q;
    remo_d     = remo_q;
    step_s     = '0;
    lane_s     = '0;
    for (int i = 0; i < ROWS; i++) begin
      acc_d[i] = acc_q[i];
      rem_d[i] = rem_q[i];
    end

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          zero_d     = (divisor == '0);
          dsor_neg_d = divisor[W-1];
          dsor_mag_d = cond_neg(divisor, divisor[W-1]);
          cnt_d      = '0;
          for (int i = 0; i < ROWS; i++) begin
            lane_s       = dividend_bus[i*W +: W];
            dvd_neg_d[i] = lane_s[W-1];
            acc_d[i]     = cond_neg(lane_s, lane_s[W-1]);
            rem_d[i]     = '0;
          end
          if (divisor == '0) begin
            state_d = S_FIX;
          end else begin
            state_d = S_ITERATE;
          end
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_ITERATE: begin
        for (int i = 0; i < ROWS; i++) begin
          step_s   = div_step(rem_q[i], acc_q[i], dsor_mag_q);
          rem_d[i] = step_s[2*W-1 -: W];
          acc_d[i] = step_s[W-1:0];
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITERATE;
        end
      end

      // A zero divisor skipped iteration, so acc still holds each dividend magnitude.
      S_FIX: begin
        for (int i = 0; i < ROWS; i++) begin
          if (zero_q) begin
            quo_d[i*W +: W]  = '0;
            remo_d[i*W +: W] = cond_neg(acc_q[i], dvd_neg_q[i]);
          end else begin
            quo_d[i*W +: W]  = cond_neg(acc_q[i], dvd_neg_q[i] ^ dsor_neg_q);
            remo_d[i*W +: W] = cond_neg(rem_q[i], dvd_neg_q[i]);
          end
        end
        dbz_d   = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and lane registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      zero_q     <= 1'b0;
      dsor_neg_q <= 1'b0;
      dsor_mag_q <= '0;
      dvd_neg_q  <= '0;
      quo_q      <= '0;
      remo_q     <= '0;
      for (int i = 0; i < ROWS; i++) begin
        acc_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      zero_q     <= zero_d;
      dsor_neg_q <= dsor_neg_d;
      dsor_mag_q <= dsor_mag_d;
      dvd_neg_q  <= dvd_neg_d;
      quo_q      <= quo_d;
      remo_q     <= remo_d;
      for (int i = 0; i < ROWS; i++) begin
        acc_q[i] <= acc_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign div_by_zero   = dbz_q;
  assign quotient_bus  = quo_q;
  assign remainder_bus = remo_q;

endmodule

// File: tb/tb_parallel_row_remainder_divider.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops and compares
// them on every done pulse, including latency and the per-lane division invariant.
module tb_parallel_row_remainder_divider;

  localparam int ROWS = 12;
  localparam int W    = 64;
  localparam logic [W-1:0] MIN_I = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] MAX_I = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] NEG_MAX_I = 64'h8000_0000_0000_0001;
  localparam logic [W-1:0] Q_MAX7 = 64'sd1317624576693539401;

  typedef struct packed {
    logic [ROWS*W-1:0] dvd;
    logic [ROWS*W-1:0] q;
    logic [ROWS*W-1:0] r;
    logic [W-1:0]      dsor;
    logic              dz;
    logic [31:0]       due;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ROWS*W-1:0] dividend_bus = '0;
  logic [W-1:0]      divisor = '0;
  logic              busy, done, div_by_zero;
  logic [ROWS*W-1:0] quotient_bus, remainder_bus;

  exp_t              sb[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                cyc = 0;
  logic [ROWS*W-1:0] cur_dvd, cur_q, cur_r;
  logic              chk_pulse = 1'b0;

  parallel_row_remainder_divider #(.ROWS(ROWS), .DATA_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dividend_bus(dividend_bus),
    .divisor(divisor), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quotient_bus(quotient_bus), .remainder_bus(remainder_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [W-1:0] dv, input logic [W-1:0] q, input logic [W-1:0] r);
    for (int i = 0; i < ROWS; i++) begin
      cur_dvd[i*W +: W] = dv;
      cur_q[i*W +: W]   = q;
      cur_r[i*W +: W]   = r;
    end
  endtask

  task automatic lane(input int i, input logic [W-1:0] dv, input logic [W-1:0] q,
                      input logic [W-1:0] r);
    cur_dvd[i*W +: W] = dv;
    cur_q[i*W +: W]   = q;
    cur_r[i*W +: W]   = r;
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic dz);
    exp_t e;
    e.dvd  = cur_dvd;
    e.q    = cur_q;
    e.r    = cur_r;
    e.dsor = d;
    e.dz   = dz;
    e.due  = 32'(cyc + (dz ? 1 : 65));
    sb.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] d, input logic dz, input logic push);
    @(negedge clk);
    dividend_bus = cur_dvd;
    divisor      = d;
    start        = 1'b1;
    @(posedge clk);
    #1;
    if (push) push_exp(d, dz);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("dbz_cleared_on_start", {63'd0, div_by_zero}, 64'd0);
    dividend_bus = {ROWS{64'hDEAD_BEEF_0BAD_F00D}};
    divisor      = 64'd13;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= 300) begin
      n_err++;
      $display("FAIL timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
    end
  endtask

  // Monitor: compare every done against the oldest expected result.
  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] a, b, rm, dm;
    if (chk_pulse && reset_n) chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk_pulse = 1'b0;
    if (reset_n && done) begin
      chk_pulse = 1'b1;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("busy_with_done", {63'd0, busy}, 64'd1);
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
        for (int i = 0; i < ROWS; i++) begin
          a = quotient_bus[i*W +: W];
          b = remainder_bus[i*W +: W];
          chk($sformatf("q[%0d]", i), a, e.q[i*W +: W]);
          chk($sformatf("r[%0d]", i), b, e.r[i*W +: W]);
          if (!e.dz) begin
            chk($sformatf("invariant[%0d]", i), a * e.dsor + b, e.dvd[i*W +: W]);
            rm = b[W-1] ? (64'd0 - b) : b;
            dm = e.dsor[W-1] ? (64'd0 - e.dsor) : e.dsor;
            chk($sformatf("rem_bound[%0d]", i), {63'd0, (rm < dm)}, 64'd1);
          end
        end
      end
    end
  end

  initial begin
    cur_dvd = '0;
    cur_q   = '0;
    cur_r   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("reset_q", {63'd0, |quotient_bus}, 64'd0);
    chk("reset_r", {63'd0, |remainder_bus}, 64'd0);
    reset_n = 1'b1;

    // Basic signs
    fill(64'd1, 64'd0, 64'd1);
    lane(0, 64'd17, 64'd3, 64'd2);
    lane(1, -64'sd17, -64'sd3, -64'sd2);
    lane(2, 64'd16, 64'd3, 64'd1);
    lane(3, 64'd0, 64'd0, 64'd0);
    issue(64'd5, 1'b0, 1'b1);
    wait_quiet();

    // Negative divisor
    fill(64'd1, 64'd0, 64'd1);
    lane(0, 64'd17, -64'sd3, 64'd2);
    lane(1, -64'sd17, 64'd3, -64'sd2);
    issue(-64'sd5, 1'b0, 1'b1);
    wait_quiet();

    // Divide by zero, then a normal start clears the flag
    fill(64'd42, 64'd0, 64'd42);
    lane(0, -64'sd9, 64'd0, -64'sd9);
    issue(64'd0, 1'b1, 1'b1);
    wait_quiet();
    chk("dbz_holds", {63'd0, div_by_zero}, 64'd1);
    fill(64'd42, 64'd14, 64'd0);
    lane(0, -64'sd10, -64'sd3, -64'sd1);
    issue(64'd3, 1'b0, 1'b1);
    wait_quiet();

    // Extremes
    fill(64'd0, 64'd0, 64'd0);
    lane(0, MIN_I, MIN_I, 64'd0);
    lane(1, MAX_I, NEG_MAX_I, 64'd0);
    issue(-64'sd1, 1'b0, 1'b1);
    wait_quiet();
    fill(64'd0, 64'd0, 64'd0);
    lane(0, MIN_I, 64'd0 - Q_MAX7, -64'sd1);
    lane(1, MAX_I, Q_MAX7, 64'd0);
    lane(2, -64'sd1, 64'd0, -64'sd1);
    lane(3, 64'd100, 64'd14, 64'd2);
    issue(64'd7, 1'b0, 1'b1);
    wait_quiet();

    // Start held high: back-to-back ops, inputs changed mid-flight, stray pulse mid-ITERATE
    fill(64'd0, 64'd0, 64'd0);
    lane(0, 64'd100, 64'd11, 64'd1);
    lane(1, -64'sd100, -64'sd11, -64'sd1);
    @(negedge clk);
    dividend_bus = cur_dvd;
    divisor      = 64'd9;
    start        = 1'b1;
    @(posedge clk);
    #1;
    push_exp(64'd9, 1'b0);
    fill(64'd0, 64'd0, 64'd0);
    lane(0, 64'd7, -64'sd3, 64'd1);
    lane(1, -64'sd7, 64'd3, -64'sd1);
    @(negedge clk);
    dividend_bus = cur_dvd;
    divisor      = -64'sd2;
    repeat (66) @(posedge clk);
    #1;
    push_exp(-64'sd2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    dividend_bus = {ROWS{64'h0000_1234_5678_9ABC}};
    divisor      = 64'd0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet();

    // Asynchronous reset mid-operation
    fill(64'd9, 64'd3, 64'd0);
    issue(64'd3, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midop_reset_busy", {63'd0, busy}, 64'd0);
    chk("midop_reset_done", {63'd0, done}, 64'd0);
    chk("midop_reset_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("midop_reset_q", {63'd0, |quotient_bus}, 64'd0);
    chk("midop_reset_r", {63'd0, |remainder_bus}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fill(64'd5, 64'd1, 64'd1);
    lane(0, 64'd1000, 64'd250, 64'd0);
    lane(1, -64'sd1001, -64'sd250, -64'sd1);
    issue(64'd4, 1'b0, 1'b1);
    wait_quiet();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
